// File: rtl/anb_wr_arbiter_m.sv
// N-to-1 write arbiter: round-robin address grant into a register slice, with a grant-order
// FIFO that steers an unregistered data mux so that bursts follow address order without interleaving.
module anb_wr_arbiter_m #(
  parameter int N_PORTS   = 4,
  parameter int ADDR_W    = 64,
  parameter int LEN_W     = 16,
  parameter int DATA_W    = 256,
  parameter int ORD_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          m_avalid,
  output logic [N_PORTS-1:0]          m_aready,
  input  logic [N_PORTS*ADDR_W-1:0]   m_addr,
  input  logic [N_PORTS*LEN_W-1:0]    m_len,
  input  logic [N_PORTS-1:0]          m_dvalid,
  output logic [N_PORTS-1:0]          m_dready,
  input  logic [N_PORTS*DATA_W-1:0]   m_data,
  input  logic [N_PORTS-1:0]          m_last,
  output logic                        s_avalid,
  input  logic                        s_aready,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [LEN_W-1:0]            s_len,
  output logic                        s_dvalid,
  input  logic                        s_dready,
  output logic [DATA_W-1:0]           s_data,
  output logic                        s_last
);

  localparam int IDX_W  = $clog2(N_PORTS);
  localparam int OPTR_W = $clog2(ORD_DEPTH);
  localparam int CNT_W  = OPTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(N_PORTS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(ORD_DEPTH);
  localparam logic [IDX_W:0]   N_WIDE    = (IDX_W+1)'(N_PORTS);

  logic [ADDR_W-1:0] w_port_addr [N_PORTS];
  logic [LEN_W-1:0]  w_port_len  [N_PORTS];
  logic [DATA_W-1:0] w_port_data [N_PORTS];

  logic [IDX_W:0]    w_sum  [N_PORTS];
  logic [IDX_W-1:0]  w_cand [N_PORTS];
  logic [N_PORTS-1:0] w_req_rot;

  logic              w_found;
  logic [IDX_W-1:0]  w_win;
  logic              w_arb_en;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic [IDX_W-1:0]  w_head;

  logic              r_s_avalid;
  logic [ADDR_W-1:0] r_s_addr;
  logic [LEN_W-1:0]  r_s_len;
  logic [IDX_W-1:0]  r_rr_ptr;

  logic [IDX_W-1:0]  r_ord_mem [ORD_DEPTH];
  logic [OPTR_W-1:0] r_wr_ptr;
  logic [OPTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Per-port views of the flattened buses, plus the rotated search order starting at r_rr_ptr.
  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    assign w_port_addr[gi] = m_addr[gi*ADDR_W +: ADDR_W];
    assign w_port_len[gi]  = m_len[gi*LEN_W +: LEN_W];
    assign w_port_data[gi] = m_data[gi*DATA_W +: DATA_W];
    assign w_sum[gi]       = {1'b0, r_rr_ptr} + (IDX_W+1)'(gi);
    assign w_cand[gi]      = (w_sum[gi] >= N_WIDE) ? IDX_W'(w_sum[gi] - N_WIDE)
                                                   : w_sum[gi][IDX_W-1:0];
    assign w_req_rot[gi]   = m_avalid[w_cand[gi]];
    assign m_aready[gi]    = w_push && (w_win == IDX_W'(gi));
    assign m_dready[gi]    = !w_empty && s_dready && (w_head == IDX_W'(gi));
  end

  always_comb begin
    w_found = 1'b0;
    w_win   = r_rr_ptr;
    for (int k = 0; k < N_PORTS; k++) begin
      if (!w_found && w_req_rot[k]) begin
        w_found = 1'b1;
        w_win   = w_cand[k];
      end
    end
  end

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_CNT);
  // Gated by rst so no requester sees a grant while reset is held.
  assign w_arb_en = !rst && (!r_s_avalid || s_aready) && !w_full;
  assign w_push   = w_arb_en && w_found;
  assign w_head   = r_ord_mem[r_rd_ptr];

  assign s_dvalid = !w_empty && m_dvalid[w_head];
  assign s_data   = w_port_data[w_head];
  assign s_last   = m_last[w_head];
  assign w_pop    = s_dvalid && s_dready && s_last;

  assign s_avalid = r_s_avalid;
  assign s_addr   = r_s_addr;
  assign s_len    = r_s_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_avalid <= 1'b0;
      r_s_addr   <= '0;
      r_s_len    <= '0;
      r_rr_ptr   <= '0;
    end else if (w_push) begin
      r_s_avalid <= 1'b1;
      r_s_addr   <= w_port_addr[w_win];
      r_s_len    <= w_port_len[w_win];
      r_rr_ptr   <= (w_win == LAST_PORT) ? '0 : w_win + IDX_W'(1);
    end else if (s_aready) begin
      r_s_avalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ord_mem[r_wr_ptr] <= w_win;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + OPTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + OPTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_anb_wr_arbiter_m.sv
// Randomised scoreboard bench for anb_wr_arbiter_m: a queue-based reference model predicts grants,
// ready vectors and the address/data streams; a monitor pops expectations at each output handshake.
module tb_anb_wr_arbiter_m;
  localparam int N     = 4;
  localparam int AW    = 64;
  localparam int LW    = 16;
  localparam int DW    = 256;
  localparam int DEPTH = 4;
  localparam int BB    = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } aexp_t;

  logic            clk;
  logic            rst;
  logic [N-1:0]    m_avalid;
  logic [N-1:0]    m_aready;
  logic [N*AW-1:0] m_addr;
  logic [N*LW-1:0] m_len;
  logic [N-1:0]    m_dvalid;
  logic [N-1:0]    m_dready;
  logic [N*DW-1:0] m_data;
  logic [N-1:0]    m_last;
  logic            s_avalid;
  logic            s_aready;
  logic [AW-1:0]   s_addr;
  logic [LW-1:0]   s_len;
  logic            s_dvalid;
  logic            s_dready;
  logic [DW-1:0]   s_data;
  logic            s_last;

  anb_wr_arbiter_m #(
    .N_PORTS(N), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW), .ORD_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .m_avalid(m_avalid), .m_aready(m_aready), .m_addr(m_addr), .m_len(m_len),
    .m_dvalid(m_dvalid), .m_dready(m_dready), .m_data(m_data), .m_last(m_last),
    .s_avalid(s_avalid), .s_aready(s_aready), .s_addr(s_addr), .s_len(s_len),
    .s_dvalid(s_dvalid), .s_dready(s_dready), .s_data(s_data), .s_last(s_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Requester-side state
  beat_t         pd_q[N][$];
  beat_t         cur_burst[N][$];
  logic [AW-1:0] cur_addr[N];
  logic [LW-1:0] cur_len[N];
  bit            req_active[N];
  bit            dv_hold[N];
  int            a_wait[N];
  int            force_beats[N];
  int            force_wait[N];
  bit [N-1:0]    port_en;
  bit            stim_on;
  int            req_pct, dv_pct, ar_pct, dr_pct, a_wait_max;

  // Reference model and scoreboard state
  bit [N-1:0]    a_fire;
  bit [N-1:0]    d_fire;
  bit            mdl_slot;
  int            mdl_rr;
  int            mdl_order[$];
  aexp_t         exp_a_q[$];
  beat_t         exp_d_q[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic new_burst(input int p, input int beats, input int wt);
    beat_t b;
    cur_addr[p] = {$urandom, $urandom};
    cur_len[p]  = LW'(beats * BB);
    cur_burst[p].delete();
    for (int i = 0; i < beats; i++) begin
      b.data = rnd_data();
      b.last = (i == beats - 1);
      cur_burst[p].push_back(b);
      pd_q[p].push_back(b);
    end
    req_active[p] = 1'b1;
    a_wait[p]     = wt;
  endtask

  // One clock of requester/sink stimulus, applied 1 unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) begin
      if (a_fire[p]) begin
        req_active[p] = 1'b0;
        cur_burst[p].delete();
      end
      if (d_fire[p] && pd_q[p].size() > 0) begin
        void'(pd_q[p].pop_front());
        dv_hold[p] = 1'b0;
      end
      if (!req_active[p]) begin
        if (force_beats[p] != 0) begin
          new_burst(p, force_beats[p], force_wait[p]);
          force_beats[p] = 0;
        end else if (stim_on && port_en[p] && pd_q[p].size() < 12 &&
                     int'($urandom_range(99)) < req_pct) begin
          new_burst(p, int'($urandom_range(4, 1)), int'($urandom_range(a_wait_max, 0)));
        end
      end else if (a_wait[p] > 0) begin
        a_wait[p]--;
      end
      m_avalid[p]           = req_active[p] && (a_wait[p] == 0);
      m_addr[p*AW +: AW]    = cur_addr[p];
      m_len[p*LW +: LW]     = cur_len[p];
      if (pd_q[p].size() > 0 && (dv_hold[p] || int'($urandom_range(99)) < dv_pct)) begin
        dv_hold[p]         = 1'b1;
        m_dvalid[p]        = 1'b1;
        m_data[p*DW +: DW] = pd_q[p][0].data;
        m_last[p]          = pd_q[p][0].last;
      end else begin
        m_dvalid[p]        = 1'b0;
        m_data[p*DW +: DW] = '0;
        m_last[p]          = 1'b0;
      end
    end
    s_aready = int'($urandom_range(99)) < ar_pct;
    s_dready = int'($urandom_range(99)) < dr_pct;
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) step();
  endtask

  task automatic clear_requesters();
    for (int p = 0; p < N; p++) begin
      pd_q[p].delete();
      cur_burst[p].delete();
      req_active[p]  = 1'b0;
      dv_hold[p]     = 1'b0;
      a_wait[p]      = 0;
      force_beats[p] = 0;
      force_wait[p]  = 0;
      cur_addr[p]    = '0;
      cur_len[p]     = '0;
    end
    m_avalid = '0;
    m_dvalid = '0;
    m_last   = '0;
    m_addr   = '0;
    m_len    = '0;
    m_data   = '0;
  endtask

  // Reference model: round-robin from the pointer among requesting ports whenever the output
  // slot can take a new address and fewer than DEPTH grants are outstanding.
  always @(negedge clk) begin
    int win, h, p;
    bit free, full;
    logic [N-1:0] exp_ar, exp_dr;
    logic exp_dv;
    if (rst) begin
      mdl_slot = 1'b0;
      mdl_rr   = 0;
      mdl_order.delete();
      exp_a_q.delete();
      exp_d_q.delete();
      a_fire   = '0;
      d_fire   = '0;
    end else begin
      free = !mdl_slot || s_aready;
      full = (mdl_order.size() >= DEPTH);
      win  = -1;
      if (free && !full) begin
        for (int k = 0; k < N; k++) begin
          p = (mdl_rr + k) % N;
          if (win < 0 && m_avalid[p]) win = p;
        end
      end
      exp_ar = '0;
      if (win >= 0) exp_ar[win] = 1'b1;
      chk("m_aready", DW'(m_aready), DW'(exp_ar));
      chk("s_avalid", DW'(s_avalid), DW'(mdl_slot));
      exp_dr = '0;
      exp_dv = 1'b0;
      h      = -1;
      if (mdl_order.size() > 0) begin
        h      = mdl_order[0];
        exp_dv = m_dvalid[h];
        if (s_dready) exp_dr[h] = 1'b1;
      end
      chk("m_dready", DW'(m_dready), DW'(exp_dr));
      chk("s_dvalid", DW'(s_dvalid), DW'(exp_dv));
      a_fire = m_avalid & m_aready;
      d_fire = m_dvalid & m_dready;
      if (h >= 0 && m_dvalid[h] && s_dready && m_last[h]) void'(mdl_order.pop_front());
      if (win >= 0) begin
        mdl_order.push_back(win);
        exp_a_q.push_back('{addr: cur_addr[win], len: cur_len[win]});
        foreach (cur_burst[win][i]) exp_d_q.push_back(cur_burst[win][i]);
        mdl_slot = 1'b1;
        mdl_rr   = (win + 1) % N;
      end else if (s_aready) begin
        mdl_slot = 1'b0;
      end
    end
  end

  // Monitor: pops expectations on each shared-channel handshake.
  always @(negedge clk) begin
    aexp_t ea;
    beat_t eb;
    if (!rst) begin
      if (s_avalid && s_aready) begin
        chk("addr_expected", DW'(exp_a_q.size() != 0), DW'(1));
        if (exp_a_q.size() != 0) begin
          ea = exp_a_q.pop_front();
          chk("s_addr", DW'(s_addr), DW'(ea.addr));
          chk("s_len", DW'(s_len), DW'(ea.len));
          $display("[TB] addr handshake addr=%h len=%0d", s_addr, s_len);
        end
      end
      if (s_dvalid && s_dready) begin
        chk("data_expected", DW'(exp_d_q.size() != 0), DW'(1));
        if (exp_d_q.size() != 0) begin
          eb = exp_d_q.pop_front();
          chk("s_data", s_data, eb.data);
          chk("s_last", DW'(s_last), DW'(eb.last));
          if (s_last) $display("[TB] burst complete, last beat data=%h", s_data[63:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    rst = 1'b1;
    s_aready = 1'b1;
    s_dready = 1'b1;
    stim_on = 1'b0;
    port_en = '1;
    req_pct = 0; dv_pct = 100; ar_pct = 100; dr_pct = 100; a_wait_max = 0;
    clear_requesters();
    m_avalid = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_avalid", DW'(s_avalid), DW'(0));
    chk("rst_s_dvalid", DW'(s_dvalid), DW'(0));
    chk("rst_m_aready", DW'(m_aready), DW'(0));
    chk("rst_m_dready", DW'(m_dready), DW'(0));
    chk("rst_s_addr", DW'(s_addr), DW'(0));
    chk("rst_s_len", DW'(s_len), DW'(0));
    m_avalid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Ports 2 and 0 together after reset: pointer at 0 grants port 0 first.
    force_beats[2] = 1; force_beats[0] = 2;
    run(15);

    // Port 1 (64 bytes) then port 3 (32 bytes).
    force_beats[1] = 2;
    step();
    force_beats[3] = 1;
    run(15);

    // Fairness: every port requesting continuously with both channels open.
    stim_on = 1'b1; req_pct = 100; dv_pct = 100; ar_pct = 100; dr_pct = 100;
    run(60);

    // Backpressure on data: grant-order FIFO fills and all address readies drop.
    dr_pct = 0;
    run(12);
    chk("full_no_aready", DW'(m_aready), DW'(0));
    dr_pct = 100;
    run(20);

    // Early data on port 2, then several bursts from port 0 alone.
    stim_on = 1'b0;
    run(30);
    force_beats[2] = 2; force_wait[2] = 3;
    run(12);
    stim_on = 1'b1; port_en = 4'b0001; dr_pct = 30;
    run(30);
    port_en = '1;

    // Random traffic with an asynchronous reset in the middle.
    req_pct = 40; dv_pct = 60; ar_pct = 60; dr_pct = 60; a_wait_max = 3;
    run(700);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_s_avalid", DW'(s_avalid), DW'(0));
    chk("midrst_s_dvalid", DW'(s_dvalid), DW'(0));
    chk("midrst_m_aready", DW'(m_aready), DW'(0));
    chk("midrst_m_dready", DW'(m_dready), DW'(0));
    clear_requesters();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    stim_on = 1'b0;
    force_beats[2] = 1; force_beats[0] = 1;
    run(10);
    stim_on = 1'b1;
    run(800);

    // Drain everything that is outstanding, with a bounded wait.
    stim_on = 1'b0; dv_pct = 100; ar_pct = 100; dr_pct = 100;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      step();
      done = (exp_a_q.size() == 0) && (exp_d_q.size() == 0) && (mdl_order.size() == 0);
      for (int p = 0; p < N; p++) done = done && !req_active[p] && (pd_q[p].size() == 0);
    end
    chk("drain_complete", DW'(done), DW'(1));
    run(3);
    chk("final_s_avalid", DW'(s_avalid), DW'(0));
    chk("final_s_dvalid", DW'(s_dvalid), DW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
